// File: rtl/sobel_stream_if.sv
// rtl/sobel_stream_if.sv - pixel-in / edge-out stream bundle for sobel_stream
// Optional SOBEL_MAG_OUT_EN adds the out_mag signal to the bundle.
interface sobel_stream_if #(
   parameter int PIX_W = 8,
   parameter int IMG_W = 640,
   parameter int IMG_H = 480,
   parameter int MAG_W = PIX_W + 3
);
   logic [MAG_W-1:0]         threshold;
   logic                     in_valid;
   logic                     in_ready;
   logic                     in_sof;
   logic [PIX_W-1:0]         in_pix;
   logic                     out_valid;
   logic                     out_ready;
   logic                     out_edge;
   logic [$clog2(IMG_W)-1:0] out_x;
   logic [$clog2(IMG_H)-1:0] out_y;
`ifdef SOBEL_MAG_OUT_EN
   logic [MAG_W-1:0]         out_mag;
`endif

   modport slave (
      input  threshold, in_valid, in_sof, in_pix, out_ready,
      output in_ready, out_valid, out_edge, out_x, out_y
`ifdef SOBEL_MAG_OUT_EN
      , output out_mag
`endif
   );

   modport master (
      output threshold, in_valid, in_sof, in_pix, out_ready,
      input  in_ready, out_valid, out_edge, out_x, out_y
`ifdef SOBEL_MAG_OUT_EN
      , input out_mag
`endif
   );
endinterface

// File: rtl/sobel_stream.sv
// rtl/sobel_stream.sv - streaming 3x3 Sobel edge detector with line buffers and valid/ready
// Optional feature macro: SOBEL_MAG_OUT_EN (registered magnitude output out_mag).
module sobel_stream #(
   parameter int PIX_W = 8,
   parameter int IMG_W = 640,
   parameter int IMG_H = 480,
   parameter int MAG_W = PIX_W + 3
) (
   input  logic          clk,
   input  logic          rst_n,
   sobel_stream_if.slave s
);
   localparam int XW = $clog2(IMG_W);
   localparam int YW = $clog2(IMG_H);
   localparam int SW = MAG_W + 1;
   localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

   logic [XW-1:0]      col, cur_col;
   logic [YW-1:0]      row, cur_row;
   logic [MAG_W-1:0]   thr_q;
   logic [PIX_W-1:0]   lb0 [IMG_W];
   logic [PIX_W-1:0]   lb1 [IMG_W];
   logic [PIX_W-1:0]   win [3][3];
   logic [PIX_W-1:0]   top_new, mid_new;
   logic               accept, produce;
   logic [PIX_W-1:0]   z1, z2, z3, z4, z6, z7, z8, z9;
   logic signed [SW-1:0] gx, gy;
   logic [MAG_W-1:0]   ax, ay, mag;

   function automatic logic signed [SW-1:0] ext(input logic [PIX_W-1:0] p);
      return $signed({{(SW-PIX_W){1'b0}}, p});
   endfunction

   assign s.in_ready = !s.out_valid || s.out_ready;
   assign accept     = s.in_valid && s.in_ready;
   // An sof pixel is always (0,0), whatever the counters held.
   assign cur_col    = s.in_sof ? '0 : col;
   assign cur_row    = s.in_sof ? '0 : row;
   assign top_new    = lb1[cur_col];
   assign mid_new    = lb0[cur_col];
   assign produce    = (cur_row >= YW'(2)) && (cur_col >= XW'(2));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col   <= '0;
         row   <= '0;
         thr_q <= '0;
      end else if (accept) begin
         if (s.in_sof)
            thr_q <= s.threshold;
         if (cur_col == X_LAST) begin
            col <= '0;
            row <= (cur_row == Y_LAST) ? '0 : cur_row + YW'(1);
         end else begin
            col <= cur_col + XW'(1);
            row <= cur_row;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         lb1[cur_col] <= mid_new;
         lb0[cur_col] <= s.in_pix;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
               win[r][c] <= '0;
      end else if (accept) begin
         for (int r = 0; r < 3; r++) begin
            win[r][0] <= win[r][1];
            win[r][1] <= win[r][2];
         end
         win[0][2] <= top_new;
         win[1][2] <= mid_new;
         win[2][2] <= s.in_pix;
      end
   end

   // Kernel sees the post-shift window so the result can be registered on this accept.
   assign z1 = win[0][1];
   assign z2 = win[0][2];
   assign z3 = top_new;
   assign z4 = win[1][1];
   assign z6 = mid_new;
   assign z7 = win[2][1];
   assign z8 = win[2][2];
   assign z9 = s.in_pix;

   always_comb begin
      gx  = (ext(z7) + (ext(z8) <<< 1) + ext(z9)) - (ext(z1) + (ext(z2) <<< 1) + ext(z3));
      gy  = (ext(z3) + (ext(z6) <<< 1) + ext(z9)) - (ext(z1) + (ext(z4) <<< 1) + ext(z7));
      ax  = MAG_W'(gx[SW-1] ? -gx : gx);
      ay  = MAG_W'(gy[SW-1] ? -gy : gy);
      mag = ax + ay;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s.out_valid <= 1'b0;
         s.out_edge  <= 1'b0;
         s.out_x     <= '0;
         s.out_y     <= '0;
      end else if (accept && produce) begin
         s.out_valid <= 1'b1;
         s.out_edge  <= (mag >= thr_q);
         s.out_x     <= cur_col - XW'(1);
         s.out_y     <= cur_row - YW'(1);
      end else if (s.out_ready) begin
         s.out_valid <= 1'b0;
      end
   end

`ifdef SOBEL_MAG_OUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         s.out_mag <= '0;
      else if (accept && produce)
         s.out_mag <= mag;
   end
`else
   // Edge-only build: magnitude is consumed solely by the threshold compare.
`endif
endmodule
